// File: rtl/decode_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_queue: small FIFO of MIPS instructions, decoded on push into a     |
// | one-hot class. Optional macro DECODE_QUEUE_ILLEGAL_EN enables out_illegal.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module decode_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [PC_W-1:0]            out_pc,
  output logic [11:0]                out_class,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  localparam int c_nop   = 0;
  localparam int c_ralu  = 1;
  localparam int c_ialu  = 2;
  localparam int c_lw    = 3;
  localparam int c_sw    = 4;
  localparam int c_beq   = 5;
  localparam int c_bne   = 6;
  localparam int c_j     = 7;
  localparam int c_jr    = 8;
  localparam int c_jal   = 9;
  localparam int c_jalr  = 10;
  localparam int c_shift = 11;

  logic [31:0]     r_inst_mem  [DEPTH];
  logic [PC_W-1:0] r_pc_mem    [DEPTH];
  logic [11:0]     r_class_mem [DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic        w_push;
  logic        w_pop;
  logic [5:0]  w_opcode;
  logic [5:0]  w_func;
  logic [11:0] w_in_class;

  assign w_opcode = in_inst[31:26];
  assign w_func   = in_inst[5:0];

  // Decode of the incoming word; stored alongside the entry so the head
  // outputs never depend on in_* combinationally.
  always_comb begin
    w_in_class = '0;
    if (in_inst == 32'd0) begin
      w_in_class[c_nop] = 1'b1;
    end else if (w_opcode == 6'h00) begin
      case (w_func)
        6'h08:               w_in_class[c_jr]    = 1'b1;
        6'h09:               w_in_class[c_jalr]  = 1'b1;
        6'h00, 6'h02, 6'h03: w_in_class[c_shift] = 1'b1;
        default:             w_in_class[c_ralu]  = 1'b1;
      endcase
    end else begin
      case (w_opcode)
        6'h08, 6'h09, 6'h0A, 6'h0B,
        6'h0C, 6'h0D, 6'h0E, 6'h0F: w_in_class[c_ialu] = 1'b1;
        6'h23:                      w_in_class[c_lw]   = 1'b1;
        6'h2B:                      w_in_class[c_sw]   = 1'b1;
        6'h04:                      w_in_class[c_beq]  = 1'b1;
        6'h05:                      w_in_class[c_bne]  = 1'b1;
        6'h02:                      w_in_class[c_j]    = 1'b1;
        6'h03:                      w_in_class[c_jal]  = 1'b1;
        default:                    w_in_class         = '0;
      endcase
    end
  end

  assign in_ready  = (r_count < c_full);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // Flush wins over any handshake in the same cycle.
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; out_* are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_inst_mem[r_wptr]  <= in_inst;
      r_pc_mem[r_wptr]    <= in_pc;
      r_class_mem[r_wptr] <= w_in_class;
    end
  end

  assign out_inst  = out_valid ? r_inst_mem[r_rptr]  : '0;
  assign out_pc    = out_valid ? r_pc_mem[r_rptr]    : '0;
  assign out_class = out_valid ? r_class_mem[r_rptr] : '0;

`ifdef DECODE_QUEUE_ILLEGAL_EN
  assign out_illegal = out_valid && (r_class_mem[r_rptr] == 12'd0);
`else
  assign out_illegal = 1'b0;
`endif

endmodule
`default_nettype wire
